ip_access_ctrl: RTL and testbench

Multi-channel successor to the single-IP LWIP/SWIP decoder.
- Decodes LWIP/SWIP plus a subopcode IP index.
- Drives the data-memory controls (datarw/dataena) and a one-hot per-IP write/read strobe.
- Holds the access until the selected IP acknowledges, stalling the CPU meanwhile, with a bounded timeout that reports an error.
- Sits between the CPU decode stage, the data memory interface and the IP bank.

---
 rtl/ip_pkg.sv | 18 +
 rtl/ip_access_ctrl_if.sv | 26 ++
 rtl/ip_onehot_sel.sv | 17 +
 rtl/ip_access_ctrl.sv | 113 +++++++++++
 tb/tb_ip_access_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/ip_pkg.sv
// rtl/ip_pkg.sv - shared opcode, state and op-type definitions for the IP access controller
package ip_pkg;

    localparam logic [5:0] LWIP = 6'b111111;
    localparam logic [5:0] SWIP = 6'b111110;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;
    localparam state_t ST_ERR    = 2'd3;

    typedef enum logic {
        OP_LWIP = 1'b0,
        OP_SWIP = 1'b1
    } op_e;

endpackage

// File: rtl/ip_access_ctrl_if.sv
// rtl/ip_access_ctrl_if.sv - CPU decode / memory / IP-bank signals of the IP access controller
interface ip_access_ctrl_if #(
    parameter int NUM_IP = 4
) ();
    logic              instr_valid;
    logic [5:0]        opcode;
    logic [4:0]        subopcode;
    logic [NUM_IP-1:0] ip_ack;
    logic              datarw;
    logic              dataena;
    logic [NUM_IP-1:0] IP_write;
    logic [NUM_IP-1:0] IP_read;
    logic              stall;
    logic              done;
    logic              err;

    modport master (
        output instr_valid, opcode, subopcode, ip_ack,
        input  datarw, dataena, IP_write, IP_read, stall, done, err
    );

    modport slave (
        input  instr_valid, opcode, subopcode, ip_ack,
        output datarw, dataena, IP_write, IP_read, stall, done, err
    );
endinterface

// File: rtl/ip_onehot_sel.sv
// rtl/ip_onehot_sel.sv - N-wide one-hot decode of a 5-bit index, gated by enable
module ip_onehot_sel #(
    parameter int N = 4
) (
    input  logic [4:0]   sel_i,
    input  logic         en_i,
    output logic [N-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = en_i && (sel_i == 5'(i));
        end
    end

endmodule

// File: rtl/ip_access_ctrl.sv
// rtl/ip_access_ctrl.sv - LWIP/SWIP decoder holding one IP access until ack or timeout
module ip_access_ctrl
    import ip_pkg::*;
#(
    parameter int NUM_IP  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    ip_access_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [4:0]        sel_q, sel_d;

    logic              datarw_q, dataena_q, stall_q, done_q, err_q;
    logic [NUM_IP-1:0] ip_write_q, ip_read_q;
    logic [NUM_IP-1:0] ip_write_d, ip_read_d;
    logic              in_access_d;
    logic              ack_hit;
    logic              is_ip_op;

    // While in ACCESS exactly one strobe bit is set, and it marks the selected channel.
    assign ack_hit  = |(bus.ip_ack & (ip_write_q | ip_read_q));
    assign is_ip_op = (bus.opcode == LWIP) || (bus.opcode == SWIP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid && is_ip_op) begin
                    if (32'(bus.subopcode) < NUM_IP) begin
                        op_d    = (bus.opcode == LWIP) ? OP_LWIP : OP_SWIP;
                        sel_d   = bus.subopcode;
                        cnt_d   = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                if (ack_hit) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_access_d = (state_d == ST_ACCESS);

    // Strobes are decoded from next-state values so every output comes straight from a flop.
    ip_onehot_sel #(.N(NUM_IP)) u_write_sel (
        .sel_i    (sel_d),
        .en_i     (in_access_d && (op_d == OP_LWIP)),
        .onehot_o (ip_write_d)
    );

    ip_onehot_sel #(.N(NUM_IP)) u_read_sel (
        .sel_i    (sel_d),
        .en_i     (in_access_d && (op_d == OP_SWIP)),
        .onehot_o (ip_read_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_LWIP;
            sel_q      <= '0;
            datarw_q   <= 1'b0;
            dataena_q  <= 1'b0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ip_write_q <= '0;
            ip_read_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            sel_q      <= sel_d;
            datarw_q   <= in_access_d && (op_d == OP_SWIP);
            dataena_q  <= in_access_d;
            stall_q    <= in_access_d;
            done_q     <= (state_d == ST_DONE);
            err_q      <= (state_d == ST_ERR);
            ip_write_q <= ip_write_d;
            ip_read_q  <= ip_read_d;
        end
    end

    assign bus.datarw   = datarw_q;
    assign bus.dataena  = dataena_q;
    assign bus.stall    = stall_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.IP_write = ip_write_q;
    assign bus.IP_read  = ip_read_q;

endmodule

// File: tb/tb_ip_access_ctrl.sv
// tb/tb_ip_access_ctrl.sv - randomized self-checking bench for ip_access_ctrl
module tb_ip_access_ctrl;

    localparam int NUM_IP  = 4;
    localparam int TIMEOUT = 16;
    localparam logic [5:0] OPC_LWIP = 6'b111111;
    localparam logic [5:0] OPC_SWIP = 6'b111110;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ip_access_ctrl_if #(.NUM_IP(NUM_IP)) bus ();

    ip_access_ctrl #(
        .NUM_IP  (NUM_IP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ctl = {datarw, dataena, stall, done, err}
    task automatic check_outputs(input string tag, input logic [4:0] ctl,
                                 input logic [NUM_IP-1:0] wr, input logic [NUM_IP-1:0] rd);
        check({tag, ".ctl"}, 32'({bus.datarw, bus.dataena, bus.stall, bus.done, bus.err}), 32'(ctl));
        check({tag, ".wr"}, 32'(bus.IP_write), 32'(wr));
        check({tag, ".rd"}, 32'(bus.IP_read), 32'(rd));
    endtask

    task automatic idle_inputs();
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.subopcode   = '0;
        bus.ip_ack      = '0;
    endtask

    task automatic noise_inputs(input logic [NUM_IP-1:0] keep_clear);
        bus.instr_valid = 1'($urandom_range(0, 1));
        bus.opcode      = ($urandom_range(0, 2) == 0) ? 6'($urandom) :
                          (($urandom_range(0, 1) == 1) ? OPC_LWIP : OPC_SWIP);
        bus.subopcode   = 5'($urandom);
        bus.ip_ack      = NUM_IP'($urandom) & ~keep_clear;
    endtask

    // One instruction from IDLE; ack_at = ACCESS cycle whose closing edge sees the ack,
    // values above TIMEOUT mean the ack never comes.
    task automatic run_access(input bit is_swip, input int idx, input int ack_at, input bit noise);
        logic [NUM_IP-1:0] oh;
        logic [NUM_IP-1:0] exp_wr;
        logic [NUM_IP-1:0] exp_rd;
        bit                timed_out;
        int                len;

        @(negedge clk);
        check_outputs("idle", 5'b0, '0, '0);
        bus.instr_valid = 1'b1;
        bus.opcode      = is_swip ? OPC_SWIP : OPC_LWIP;
        bus.subopcode   = 5'(idx);
        bus.ip_ack      = noise ? NUM_IP'($urandom) : '0;

        if (idx >= NUM_IP) begin
            @(negedge clk);
            check_outputs($sformatf("illegal%0d", idx), 5'b00001, '0, '0);
            if (noise) noise_inputs('0); else idle_inputs();
            return;
        end

        oh        = NUM_IP'(1) << idx;
        exp_wr    = is_swip ? '0 : oh;
        exp_rd    = is_swip ? oh : '0;
        timed_out = (ack_at > TIMEOUT);
        len       = timed_out ? TIMEOUT : ack_at;

        for (int j = 1; j <= len; j++) begin
            @(negedge clk);
            check_outputs($sformatf("access%0d", j), {is_swip, 1'b1, 1'b1, 1'b0, 1'b0}, exp_wr, exp_rd);
            if (noise) noise_inputs(oh); else idle_inputs();
            if (j == ack_at) bus.ip_ack = bus.ip_ack | oh;
        end

        @(negedge clk);
        check_outputs(timed_out ? "timeout" : "done", timed_out ? 5'b00001 : 5'b00010, '0, '0);
        if (noise) noise_inputs('0); else idle_inputs();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_outputs("reset", 5'b0, '0, '0);
        rst = 1'b0;

        // reset in the middle of an LWIP access to channel 2
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode      = OPC_LWIP;
        bus.subopcode   = 5'd2;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check_outputs("pre_rst", 5'b01100, NUM_IP'(4), '0);
        rst = 1'b1;
        @(negedge clk);
        check_outputs("mid_rst", 5'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        bus.ip_ack = NUM_IP'(4);
        @(negedge clk);
        check_outputs("post_rst", 5'b0, '0, '0);
        idle_inputs();

        run_access(1'b0, 1, 3, 1'b0);
        run_access(1'b1, 3, 1, 1'b0);
        run_access(1'b0, 0, TIMEOUT + 1, 1'b0);
        run_access(1'b0, 0, TIMEOUT, 1'b0);
        run_access(1'b1, 5, 1, 1'b0);
        run_access(1'b0, 2, 5, 1'b1);
        run_access(1'b0, 1, 2, 1'b0);
        run_access(1'b1, 31, 1, 1'b1);

        for (int t = 0; t < 80; t++) begin
            automatic bit is_swip = 1'($urandom_range(0, 1));
            automatic int idx     = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NUM_IP, 31))
                                                                : int'($urandom_range(0, NUM_IP - 1));
            automatic int ack_at  = int'($urandom_range(1, TIMEOUT + 2));
            automatic bit noise   = 1'($urandom_range(0, 1));
            run_access(is_swip, idx, ack_at, noise);
        end

        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check_outputs("final_idle", 5'b0, '0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
